// File: rtl/ctrl_pkg.sv
// Shared types and constants for the picture transfer controller.
// Imported by the top level and the byte serializer.
package ctrl_pkg;

  localparam int WORD_WIDTH     = 32;
  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_IDX_WIDTH = 2;

  typedef enum logic [2:0] {
    LOAD,
    START,
    COMPUTE,
    FETCH,
    LATCH,
    SEND,
    GAP
  } state_t;

endpackage

// File: rtl/word_to_byte_tx.sv
// Holds one 32-bit word and presents it LSB-first, one byte per
// stb/ack exchange; the caller's FSM inserts the idle gap cycles.
module word_to_byte_tx
  import ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [WORD_WIDTH-1:0] word,
  input  logic                  send,
  input  logic                  tx_ack,
  output logic [7:0]            tx_byte,
  output logic                  tx_stb,
  output logic                  byte_acked,
  output logic                  word_sent
);

  localparam logic [BYTE_IDX_WIDTH-1:0] K_LAST =
    BYTE_IDX_WIDTH'(BYTES_PER_WORD - 1);

  logic [WORD_WIDTH-1:0]     word_q;
  logic [BYTE_IDX_WIDTH-1:0] k_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_q <= '0;
      k_q    <= '0;
    end else if (load) begin
      word_q <= word;
      k_q    <= '0;
    end else if (byte_acked) begin
      k_q <= k_q + 1'b1;
    end
  end

  // Acks outside an active byte window are dropped here.
  assign byte_acked = send & tx_ack;
  assign word_sent  = byte_acked && (k_q == K_LAST);
  assign tx_stb     = send;
  assign tx_byte    = send ? word_q[{k_q, 3'b000} +: 8] : '0;

endmodule

// File: rtl/picture_transfer_ctrl.sv
// Packs received picture bytes into memory, kicks the accelerator,
// then streams the result region back out byte by byte.
module picture_transfer_ctrl
  import ctrl_pkg::*;
#(
  parameter int P_IMAGE_WORDS   = 25344,
  parameter int P_RESULT_OFFSET = 25344,
  parameter int P_ADDR_WIDTH    = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7:0]              rx_byte,
  input  logic                    rx_stb,
  output logic [7:0]              tx_byte,
  output logic                    tx_stb,
  input  logic                    tx_ack,
  output logic                    mem_en,
  output logic                    mem_we,
  output logic [P_ADDR_WIDTH-1:0] mem_addr,
  output logic [WORD_WIDTH-1:0]   mem_dataW,
  input  logic [WORD_WIDTH-1:0]   mem_dataR,
  output logic                    start,
  input  logic                    finish,
  output logic                    busy,
  output logic                    done
);

  localparam logic [P_ADDR_WIDTH-1:0] LAST_IDX =
    P_ADDR_WIDTH'(P_IMAGE_WORDS - 1);
  localparam logic [P_ADDR_WIDTH-1:0] RES_OFFS =
    P_ADDR_WIDTH'(P_RESULT_OFFSET);

  state_t state_q, state_d;

  logic [P_ADDR_WIDTH-1:0]   word_idx_q;
  logic [BYTE_IDX_WIDTH-1:0] byte_idx_q;
  logic [23:0]               pack_q;
  logic [WORD_WIDTH-1:0]     wdata_q;
  logic                      wr_pend_q;
  logic                      done_q;

  logic last_word;
  logic rx_take;
  logic fetch;
  logic byte_acked;
  logic word_sent;

  assign last_word = (word_idx_q == LAST_IDX);
  assign rx_take   = (state_q == LOAD) && rx_stb;
  assign fetch     = (state_q == FETCH);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= LOAD;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LOAD:    if (wr_pend_q && last_word) state_d = START;
      START:   state_d = COMPUTE;
      COMPUTE: if (finish) state_d = FETCH;
      FETCH:   state_d = LATCH;
      LATCH:   state_d = SEND;
      SEND: begin
        if (word_sent)       state_d = last_word ? LOAD : FETCH;
        else if (byte_acked) state_d = GAP;
      end
      GAP:     state_d = SEND;
      default: state_d = LOAD;
    endcase
  end

  // The 4th byte bypasses the pack register so the next word
  // can start filling in the same cycle its predecessor is written.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_idx_q <= '0;
      byte_idx_q <= '0;
      pack_q     <= '0;
      wdata_q    <= '0;
      wr_pend_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      wr_pend_q <= 1'b0;
      done_q    <= 1'b0;
      if (rx_take) begin
        unique case (byte_idx_q)
          2'd0: pack_q[7:0]   <= rx_byte;
          2'd1: pack_q[15:8]  <= rx_byte;
          2'd2: pack_q[23:16] <= rx_byte;
          default: begin
            wdata_q   <= {rx_byte, pack_q};
            wr_pend_q <= 1'b1;
          end
        endcase
        byte_idx_q <= byte_idx_q + 1'b1;
      end
      if (wr_pend_q) begin
        word_idx_q <= last_word ? '0 : word_idx_q + 1'b1;
      end
      if (state_q == START) begin
        word_idx_q <= '0;
        byte_idx_q <= '0;
      end
      if ((state_q == SEND) && word_sent) begin
        if (last_word) begin
          word_idx_q <= '0;
          done_q     <= 1'b1;
        end else begin
          word_idx_q <= word_idx_q + 1'b1;
        end
      end
    end
  end

  word_to_byte_tx u_tx (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (state_q == LATCH),
    .word       (mem_dataR),
    .send       (state_q == SEND),
    .tx_ack     (tx_ack),
    .tx_byte    (tx_byte),
    .tx_stb     (tx_stb),
    .byte_acked (byte_acked),
    .word_sent  (word_sent)
  );

  always_comb begin
    mem_addr = '0;
    unique case (1'b1)
      wr_pend_q: mem_addr = word_idx_q;
      fetch:     mem_addr = RES_OFFS + word_idx_q;
      default:   mem_addr = '0;
    endcase
  end

  assign mem_en    = wr_pend_q | fetch;
  assign mem_we    = wr_pend_q;
  assign mem_dataW = wr_pend_q ? wdata_q : '0;
  assign start     = (state_q == START);
  assign busy      = (state_q != LOAD);
  assign done      = done_q;

endmodule

// File: tb/tb_picture_transfer_ctrl.sv
// Directed and randomized checks of picture_transfer_ctrl against a
// byte/word reference model with a small word memory.
module tb_picture_transfer_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_byte;
  logic        rx_stb;
  logic [7:0]  tx_byte;
  logic        tx_stb;
  logic        tx_ack;
  logic        mem_en;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_dataW;
  logic [31:0] mem_dataR;
  logic        start;
  logic        finish;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [16];
  logic [47:0] wr_q [$];
  logic [15:0] rd_q [$];
  logic [7:0]  got [$];
  int          done_cnt = 0;
  int          start_cnt = 0;
  int          en_cnt = 0;

  picture_transfer_ctrl #(
    .P_IMAGE_WORDS   (2),
    .P_RESULT_OFFSET (4),
    .P_ADDR_WIDTH    (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_byte   (rx_byte),
    .rx_stb    (rx_stb),
    .tx_byte   (tx_byte),
    .tx_stb    (tx_stb),
    .tx_ack    (tx_ack),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_dataW (mem_dataW),
    .mem_dataR (mem_dataR),
    .start     (start),
    .finish    (finish),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (mem_en && !mem_we) mem_dataR <= mem[mem_addr[3:0]];

  always @(negedge clk) begin
    if (mem_en && mem_we) wr_q.push_back({mem_addr, mem_dataW});
    if (mem_en && !mem_we) rd_q.push_back(mem_addr);
    if (mem_en) en_cnt++;
    if (done) done_cnt++;
    if (start) start_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int idle);
    rx_byte = b;
    rx_stb  = 1'b1;
    tick();
    rx_stb  = 1'b0;
    rx_byte = 8'h00;
    repeat (idle) tick();
  endtask

  function automatic logic [63:0] all_outs();
    return {2'b00, tx_byte, tx_stb, mem_en, mem_we, mem_addr,
            mem_dataW, start, busy, done};
  endfunction

  function automatic logic [7:0] byte_of(input logic [31:0] w,
                                         input int k);
    return 8'((w / (32'd1 << (8 * k))) % 256);
  endfunction

  task automatic recv_bytes(input int slow_idx, input bit spur);
    logic [7:0] b;
    int t;
    int d;
    int bad;
    got.delete();
    for (int i = 0; i < 8; i++) begin
      t = 0;
      while (tx_stb !== 1'b1 && t < 50) begin
        tick();
        t++;
      end
      check($sformatf("stb_wait%0d", i), 64'(tx_stb), 64'd1);
      if (tx_stb !== 1'b1) return;
      b   = tx_byte;
      d   = (i == slow_idx) ? 500 : int'($urandom_range(0, 3));
      bad = 0;
      repeat (d) begin
        tick();
        if (tx_stb !== 1'b1 || tx_byte !== b) bad++;
      end
      check($sformatf("hold%0d", i), 64'(bad), 64'd0);
      got.push_back(b);
      tx_ack = 1'b1;
      tick();
      tx_ack = 1'b0;
      check($sformatf("gap%0d", i), 64'(tx_stb), 64'd0);
      if (i == 7) begin
        check("done_busy", 64'({done, busy}), 64'd2);
        tick();
        check("done_low", 64'(done), 64'd0);
      end else if (spur && (i % 4) != 3) begin
        tx_ack = 1'b1;
        tick();
        tx_ack = 1'b0;
      end
    end
  endtask

  initial begin
    logic [7:0]  pic [8];
    logic [31:0] res [2];
    logic [31:0] w;
    int s0;
    int d0;
    int e0;
    int t;

    rst_n   = 1'b0;
    rx_byte = 8'h00;
    rx_stb  = 1'b0;
    tx_ack  = 1'b0;
    finish  = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    tick();
    tick();
    check("reset_outs", all_outs(), 64'd0);
    rst_n = 1'b1;
    tick();

    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    rst_n = 1'b0;
    tick();
    check("midrst_outs", all_outs(), 64'd0);
    rst_n = 1'b1;
    wr_q.delete();
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    send_byte(8'h33, 0);
    send_byte(8'h44, 0);
    check("rst_wr", 64'({mem_en, mem_we, mem_addr, mem_dataW}),
          64'({2'b11, 16'd0, 32'h44332211}));
    tick();
    check("rst_wr_n", 64'(wr_q.size()), 64'd1);

    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    wr_q.delete();
    for (int i = 1; i <= 4; i++) send_byte(8'(i), 0);
    check("wr0", 64'({mem_en, mem_we, mem_addr, mem_dataW}),
          64'({2'b11, 16'd0, 32'h04030201}));
    for (int i = 5; i <= 8; i++) send_byte(8'(i), 0);
    check("wr1", 64'({mem_en, mem_we, mem_addr, mem_dataW}),
          64'({2'b11, 16'd1, 32'h08070605}));
    check("pre_start", 64'({start, busy}), 64'd0);
    tick();
    check("start_hi", 64'({start, busy, mem_en}), 64'b110);
    tick();
    check("start_lo", 64'({start, busy}), 64'b01);
    check("wr_n", 64'(wr_q.size()), 64'd2);

    e0 = en_cnt;
    send_byte(8'hFF, 3);
    check("cmp_quiet", 64'({tx_stb, busy}), 64'b01);
    check("cmp_en", 64'(en_cnt - e0), 64'd0);
    check("cmp_wr_n", 64'(wr_q.size()), 64'd2);

    mem[4] = 32'hA1B2C3D4;
    mem[5] = 32'h0D0C0B0A;
    rd_q.delete();
    d0 = done_cnt;
    finish = 1'b1;
    tick();
    finish = 1'b0;
    check("fetch0", 64'({mem_en, mem_we, mem_addr}),
          64'({2'b10, 16'd4}));
    recv_bytes(2, 1'b1);
    check("rx_n", 64'(got.size()), 64'd8);
    for (int i = 0; i < 8 && i < got.size(); i++)
      check($sformatf("txb%0d", i), 64'(got[i]),
            64'(byte_of(mem[4 + i / 4], i % 4)));
    check("rd_n", 64'(rd_q.size()), 64'd2);
    if (rd_q.size() == 2) begin
      check("rd0", 64'(rd_q[0]), 64'd4);
      check("rd1", 64'(rd_q[1]), 64'd5);
    end
    check("done_n", 64'(done_cnt - d0), 64'd1);
    check("idle_busy", 64'(busy), 64'd0);

    for (int it = 0; it < 3; it++) begin
      for (int i = 0; i < 8; i++) pic[i] = 8'($urandom);
      for (int i = 0; i < 2; i++) res[i] = $urandom;
      mem[4] = res[0];
      mem[5] = res[1];
      wr_q.delete();
      rd_q.delete();
      s0 = start_cnt;
      d0 = done_cnt;
      for (int i = 0; i < 8; i++)
        send_byte(pic[i], int'($urandom_range(0, 2)));
      t = 0;
      while (start_cnt == s0 && t < 20) begin
        tick();
        t++;
      end
      check($sformatf("r%0d_start", it), 64'(start_cnt - s0), 64'd1);
      check($sformatf("r%0d_wr_n", it), 64'(wr_q.size()), 64'd2);
      for (int k = 0; k < 2 && k < wr_q.size(); k++) begin
        w = 32'(pic[4*k]) + 32'(pic[4*k+1]) * 256 +
            32'(pic[4*k+2]) * 65536 + 32'(pic[4*k+3]) * 16777216;
        check($sformatf("r%0d_wr%0d", it, k), 64'(wr_q[k]),
              64'({16'(k), w}));
      end
      repeat ($urandom_range(0, 5)) tick();
      finish = 1'b1;
      tick();
      finish = 1'b0;
      recv_bytes(-1, 1'($urandom_range(0, 1)));
      check($sformatf("r%0d_rx_n", it), 64'(got.size()), 64'd8);
      for (int i = 0; i < 8 && i < got.size(); i++)
        check($sformatf("r%0d_txb%0d", it, i), 64'(got[i]),
              64'(byte_of(res[i / 4], i % 4)));
      check($sformatf("r%0d_rd_n", it), 64'(rd_q.size()), 64'd2);
      check($sformatf("r%0d_done", it), 64'(done_cnt - d0), 64'd1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
